// File: rtl/ntt_pkg.sv
// Shared NTT constants: default operand width, modulus and the modular inverse of 2.
package ntt_pkg;
    localparam int NTT_N  = 14;
    localparam int NTT_Q  = 12289;
    localparam int Q_INV2 = (NTT_Q + 1) / 2;
endpackage

// File: rtl/gs_modred.sv
// Reduces a 2N-bit product into [0,Q). Combinational; the caller registers the result.
module gs_modred
    import ntt_pkg::*;
#(
    parameter int N = NTT_N,
    parameter int Q = NTT_Q
) (
    input  logic [2*N-1:0] i_x,
    output logic [N-1:0]   o_r
);
    // Constant divisor, so the remainder maps to a fixed reduction network.
    assign o_r = N'(i_x % (2*N)'(Q));
endmodule

// File: rtl/intt_gs_pe.sv
// Gentleman-Sande inverse-NTT butterfly, 3-stage valid/ready pipeline with bubble compression.
// Optional macro INTT_HALVE_EN folds a multiply by 2^-1 mod Q into the final stage.
module intt_gs_pe
    import ntt_pkg::*;
#(
    parameter int N = NTT_N,
    parameter int Q = NTT_Q
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] u,
    input  logic [N-1:0] v,
    input  logic [N-1:0] w,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] s0,
    output logic [N-1:0] s1
);
    logic [3:1]     r_vld;
    logic [3:1]     w_adv;
    logic [N:0]     w_sum;
    logic [N-1:0]   w_s0_1, w_d_1;
    logic [N-1:0]   r_s0_1, r_d_1, r_w_1;
    logic [N-1:0]   r_s0_2;
    logic [2*N-1:0] r_prod_2;
    logic [N-1:0]   w_red, w_s0_3, w_s1_3;
    logic [N-1:0]   r_s0_3, r_s1_3;

    // A stage may load when it is empty or its successor is moving.
    assign w_adv[3] = !r_vld[3] || out_ready;
    assign w_adv[2] = !r_vld[2] || w_adv[3];
    assign w_adv[1] = !r_vld[1] || w_adv[2];
    assign in_ready = !r_vld[3] || out_ready;

    assign w_sum  = {1'b0, u} + {1'b0, v};
    assign w_s0_1 = (w_sum >= (N+1)'(Q)) ? N'(w_sum - (N+1)'(Q)) : N'(w_sum);
    // Wraps modulo 2^N; the true value lies in [0,Q) so the low N bits are exact.
    assign w_d_1  = (u >= v) ? (u - v) : (u + N'(Q) - v);

    gs_modred #(.N(N), .Q(Q)) u_modred (
        .i_x (r_prod_2),
        .o_r (w_red)
    );

`ifdef INTT_HALVE_EN
    function automatic logic [N-1:0] halve(input logic [N-1:0] x);
        logic [N:0] t;
        t = {1'b0, x} + (x[0] ? (N+1)'(Q) : '0);
        return t[N:1];
    endfunction
    assign w_s0_3 = halve(r_s0_2);
    assign w_s1_3 = halve(w_red);
`else
    assign w_s0_3 = r_s0_2;
    assign w_s1_3 = w_red;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_vld  <= '0;
            r_s0_3 <= '0;
            r_s1_3 <= '0;
        end else begin
            if (w_adv[1]) r_vld[1] <= in_valid && in_ready;
            if (w_adv[2]) r_vld[2] <= r_vld[1];
            if (w_adv[3]) begin
                r_vld[3] <= r_vld[2];
                r_s0_3   <= w_s0_3;
                r_s1_3   <= w_s1_3;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_adv[1]) begin
            r_s0_1 <= w_s0_1;
            r_d_1  <= w_d_1;
            r_w_1  <= w;
        end
        if (w_adv[2]) begin
            r_s0_2   <= r_s0_1;
            r_prod_2 <= {{N{1'b0}}, r_d_1} * {{N{1'b0}}, r_w_1};
        end
    end

    assign out_valid = r_vld[3];
    assign s0        = r_s0_3;
    assign s1        = r_s1_3;
endmodule

// File: tb/tb_intt_gs_pe.sv
// Directed self-checking bench for intt_gs_pe (N=14, Q=12289); honours INTT_HALVE_EN.
module tb_intt_gs_pe;
    import ntt_pkg::*;

    logic        clk = 1'b0;
    logic        rst, in_valid, in_ready, out_valid, out_ready;
    logic [13:0] u, v, w, s0, s1;
    int          checks = 0;
    int          errors = 0;

    intt_gs_pe #(.N(14), .Q(12289)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .u(u), .v(v), .w(w), .out_valid(out_valid), .out_ready(out_ready),
        .s0(s0), .s1(s1)
    );

    always #5 clk = ~clk;

    // Final-stage scaling applied to a plain result.
    function automatic int post(input int x);
`ifdef INTT_HALVE_EN
        return (x * Q_INV2) % 12289;
`else
        return x;
`endif
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; u = '0; v = '0; w = '0;
        tick(); tick();
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        checks++;
        if (s0 !== 14'd0 || s1 !== 14'd0) begin errors++; $display("FAIL reset_outputs got s0=%0d s1=%0d want 0 0", s0, s1); end
        rst = 1'b0;
        tick();
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    endtask

    task automatic test_single(input string name, input int iu, input int iv, input int iw,
                               input int e0, input int e1);
        u = 14'(iu); v = 14'(iv); w = 14'(iw); in_valid = 1'b1; out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL %s_in_ready got %b want 1", name, in_ready); end
        tick();
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL %s_lat1 got out_valid=%b want 0", name, out_valid); end
        tick();
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL %s_lat2 got out_valid=%b want 0", name, out_valid); end
        tick();
        checks++;
        if (out_valid !== 1'b1) begin errors++; $display("FAIL %s_lat3 got out_valid=%b want 1", name, out_valid); end
        checks++;
        if (s0 !== 14'(e0) || s1 !== 14'(e1))
        begin errors++; $display("FAIL %s_data got s0=%0d s1=%0d want %0d %0d", name, s0, s1, e0, e1); end
        tick();
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL %s_drain got out_valid=%b want 0", name, out_valid); end
    endtask

    task automatic test_vectors;
`ifdef INTT_HALVE_EN
        test_single("v531", 5, 3, 2, 4, 2);
        test_single("v351", 3, 5, 1, 4, 12288);
        test_single("vmax1", 12288, 1, 0, 0, 0);
        test_single("vmaxw", 12288, 0, 12288, 6144, 6145);
`else
        test_single("v531", 5, 3, 2, 8, 4);
        test_single("v351", 3, 5, 1, 8, 12287);
        test_single("vmax1", 12288, 1, 0, 0, 0);
        test_single("vmaxw", 12288, 0, 12288, 12288, 1);
`endif
    endtask

    // Triple i = (i+10, i, i+1): s0 = 2i+10, s1 = 10(i+1) before scaling.
    task automatic test_back_to_back;
        int ii = 0;
        int oi = 0;
        for (int c = 0; c < 40 && oi < 8; c++) begin
            in_valid  = (ii < 8);
            u = 14'(ii + 10); v = 14'(ii); w = 14'(ii + 1);
            out_ready = !(c >= 4 && c <= 6);
            #1;
            if (out_valid && !out_ready) begin
                checks++;
                if (s0 !== 14'(post(2*oi + 10)) || s1 !== 14'(post(10*(oi + 1))))
                begin errors++; $display("FAIL b2b_stall_hold c=%0d got %0d %0d want %0d %0d", c, s0, s1, post(2*oi+10), post(10*(oi+1))); end
            end
            if (out_valid && out_ready) begin
                checks++;
                if (s0 !== 14'(post(2*oi + 10)) || s1 !== 14'(post(10*(oi + 1))))
                begin errors++; $display("FAIL b2b_data idx=%0d got %0d %0d want %0d %0d", oi, s0, s1, post(2*oi+10), post(10*(oi+1))); end
                oi++;
            end
            if (in_valid && in_ready) ii++;
            tick();
        end
        in_valid = 1'b0; out_ready = 1'b1;
        checks++;
        if (oi != 8) begin errors++; $display("FAIL b2b_count got %0d results want 8", oi); end
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_extra cycle=%0d got out_valid=%b want 0", k, out_valid); end
            tick();
        end
    endtask

    task automatic test_reset_flush;
        out_ready = 1'b1;
        in_valid = 1'b1; u = 14'd7; v = 14'd2; w = 14'd9;
        tick();
        u = 14'd100; v = 14'd50; w = 14'd3;
        tick();
        in_valid = 1'b0; rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_after_rst got out_valid=%b want 0", out_valid); end
        for (int k = 0; k < 6; k++) begin
            tick();
            checks++;
            if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_stale cycle=%0d got out_valid=%b want 0", k, out_valid); end
        end
    endtask

    initial begin
        test_reset();
        test_vectors();
        test_back_to_back();
        test_reset_flush();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/intt_gs_pe.md
INTT_GS_PE -- requirements
Module: intt_gs_pe

Interface
REQ-001 Parameter N, default 14: operand/result width in bits.
REQ-002 Parameter Q, default 12289: prime modulus; Q < 2^N SHALL hold.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 in_valid  input  1  operand triple (u, v, w) is valid this cycle.
REQ-006 in_ready  output  1  block accepts the triple this cycle.
REQ-007 u  input  N  top butterfly operand, in [0,Q).
REQ-008 v  input  N  bottom butterfly operand, in [0,Q).
REQ-009 w  input  N  inverse twiddle factor, in [0,Q).
REQ-010 out_valid  output  1  result pair is valid.
REQ-011 out_ready  input  1  downstream accepts the result pair.
REQ-012 s0  output  N  top result.
REQ-013 s1  output  N  bottom result.

Function
REQ-014 The block SHALL compute the Gentleman-Sande (inverse-NTT) butterfly: s0 = (u + v) mod Q, s1 = ((u - v) * w) mod Q; results always in [0,Q).
REQ-015 Pipeline SHALL have three register stages: S1 modular add/sub (u+v, u-v with conditional +Q/-Q correction), S2 full 2N-bit product of (u-v) mod Q and w, S3 reduction of the 2N-bit product mod Q; s0 travels alongside.
REQ-016 Transfer in/out SHALL occur only on a cycle where valid and ready are both high.
REQ-017 Latency SHALL be exactly 3 cycles from input transfer to out_valid when out_ready is held high.
REQ-018 Throughput SHALL be one triple per cycle with out_ready high.
REQ-019 Back-pressure: when out_valid=1 and out_ready=0, all stages SHALL hold; in_ready = !out_valid || out_ready (combinational).
REQ-020 Bubbles SHALL be compressed: an empty stage SHALL advance regardless of out_ready.
REQ-021 s0/s1 SHALL remain stable while out_valid=1 and out_ready=0.
REQ-022 Simultaneous input and output transfer in one cycle SHALL lose no data.
REQ-023 u - v < 0 SHALL wrap to u - v + Q; u + v >= Q SHALL wrap to u + v - Q.
REQ-024 Intermediate product width SHALL be 2N bits; no truncation before reduction.

Reset
REQ-025 While rst=1 at a clock edge, all stage valid bits SHALL clear; out_valid=0, s0=0, s1=0 after that edge.
REQ-026 Reset mid-operation SHALL discard in-flight results; no stale result SHALL emerge after rst deasserts.
REQ-027 in_ready SHALL be 1 in the cycle following reset.

Configuration
REQ-028 Macro INTT_HALVE_EN: when defined, S3 SHALL additionally multiply both s0 and s1 by 2^-1 mod Q (x even -> x>>1; x odd -> (x+Q)>>1), latency unchanged; when undefined, no halving and no halving logic present.

Structure
REQ-029 Package ntt_pkg SHALL hold default N, Q, and the derived constant Q_INV2 = (Q+1)/2.
REQ-030 One sub-module gs_modred SHALL perform 2N-bit to [0,Q) reduction in S3.

Verification (Q=12289, N=14)
REQ-031 u=5, v=3, w=2 -> s0=8, s1=4 after 3 cycles (halve enabled: 4, 2).
REQ-032 u=3, v=5, w=1 -> s0=8, s1=12287 (halve enabled: 4, 12288).
REQ-033 u=12288, v=1, w=0 -> s0=0, s1=0; u=12288, v=0, w=12288 -> s0=12288, s1=1.
REQ-034 Stream 8 triples, out_ready low cycles 4-6 -> all 8 results in order, none dropped or duplicated, outputs stable while stalled.
REQ-035 Assert rst one cycle with 2 triples in flight -> out_valid=0 next cycle; no result from those triples ever appears.
